// File: rtl/hack_boot_loader_if.sv
// Byte stream from the host serial receiver into the boot loader (valid/ready).
interface hack_boot_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/hack_boot_loader.sv
// Streams a length-prefixed Hack image into the instruction ROM, holding the CPU in reset until done.
// Optional trailing XOR checksum byte enabled with `define BOOT_CHECKSUM_EN.
module hack_boot_loader #(
  parameter int ADDR_W         = 15,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  hack_boot_loader_if.slave   rx,
  input  logic                boot_start,
  output logic                rom_we,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic [15:0]         rom_wdata,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR
`ifdef BOOT_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]     MAX_WORDS = 32'd1 << ADDR_W;

  state_t              state;
  logic [15:0]         len;
  logic [7:0]          hi;
  logic [ADDR_W-1:0]   idx;
  logic [TW-1:0]       tmo_cnt;
  logic                take, counting, tmo_exp, last, len_bad;
  logic [15:0]         len_in;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  always_comb begin
    rx.rx_ready = 1'b0;
    counting    = 1'b0;
    case (state)
      LEN_HI:                   rx.rx_ready = 1'b1;
      LEN_LO, DATA_HI, DATA_LO: begin rx.rx_ready = 1'b1; counting = 1'b1; end
`ifdef BOOT_CHECKSUM_EN
      CSUM:                     begin rx.rx_ready = 1'b1; counting = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign take    = rx.rx_valid && rx.rx_ready;
  // An accepted byte in the expiring cycle beats the timeout.
  assign tmo_exp = counting && !take && (tmo_cnt == TMO_LAST);
  assign len_in  = {len[15:8], rx.rx_data};
  assign len_bad = (len_in == 16'd0) || (32'(len_in) > MAX_WORDS);
  // Compare in 32 bits so a full 2**ADDR_W image never sees a wrapped index.
  assign last    = (32'(idx) == 32'(len) - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LEN_HI;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      idx       <= '0;
      tmo_cnt   <= '0;
      len       <= '0;
      hi        <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      rom_we  <= 1'b0;
      tmo_cnt <= (counting && !take) ? tmo_cnt + 1'b1 : '0;
`ifdef BOOT_CHECKSUM_EN
      if (take) csum <= csum ^ rx.rx_data;
`endif
      if (tmo_exp) begin
        state <= ERROR; error <= 1'b1; busy <= 1'b0;
      end else begin
        case (state)
          LEN_HI: if (take) begin len[15:8] <= rx.rx_data; state <= LEN_LO; end
          LEN_LO: if (take) begin
            if (len_bad) begin
              state <= ERROR; error <= 1'b1; busy <= 1'b0;
            end else begin
              len <= len_in; idx <= '0; state <= DATA_HI;
            end
          end
          DATA_HI: if (take) begin hi <= rx.rx_data; state <= DATA_LO; end
          DATA_LO: if (take) begin
            rom_we    <= 1'b1;
            rom_addr  <= idx;
            rom_wdata <= {hi, rx.rx_data};
            state     <= WRITE;
          end
          WRITE: begin
            if (last) begin
`ifdef BOOT_CHECKSUM_EN
              state <= CSUM;
`else
              state <= DONE; done <= 1'b1; busy <= 1'b0; cpu_reset <= 1'b0;
`endif
            end else begin
              idx   <= idx + 1'b1;
              state <= DATA_HI;
            end
          end
`ifdef BOOT_CHECKSUM_EN
          CSUM: if (take) begin
            if (rx.rx_data == csum) begin
              state <= DONE; done <= 1'b1; busy <= 1'b0; cpu_reset <= 1'b0;
            end else begin
              state <= ERROR; error <= 1'b1; busy <= 1'b0;
            end
          end
`endif
          DONE, ERROR: if (boot_start) begin
            state     <= LEN_HI;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            idx       <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum      <= '0;
`endif
          end
          default: state <= LEN_HI;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Randomized scoreboard bench for hack_boot_loader with a stream-level reference model.
module tb_hack_boot_loader;
  localparam int AW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, boot_start, rom_we, cpu_reset, busy, done, error;
  logic [AW-1:0]  rom_addr;
  logic [15:0]    rom_wdata;

  hack_boot_loader_if rx ();

  hack_boot_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx(rx), .boot_start(boot_start),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  typedef struct packed { logic [AW-1:0] a; logic [15:0] d; } wr_t;

  int         total = 0, bad = 0;
  wr_t        exp_q[$];
  logic [7:0] stim_q[$];
  logic [15:0] fixed_w[$];
  bit         exp_err;
  int         exp_lat;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // Monitor: every ROM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b0 && rom_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexp_write addr=%0h data=%0h want=none", rom_addr, rom_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(rom_addr), 32'(e.a));
        chk("wr_data", 32'(rom_wdata), 32'(e.d));
        chk("rdy_in_write", 32'(rx.rx_ready), 32'd0);
      end
    end
  end

  // Reference model: build the byte stream for an N-word image and predict the outcome.
  task automatic build(int n, bit csum_ok);
    logic [15:0] w;
    logic [7:0]  x;
    wr_t         e;
    stim_q.delete();
    stim_q.push_back(n[15:8]);
    stim_q.push_back(n[7:0]);
    if (n == 0 || n > (1 << AW)) begin
      exp_err = 1'b1; exp_lat = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = (i < fixed_w.size()) ? fixed_w[i] : 16'($urandom);
        stim_q.push_back(w[15:8]);
        stim_q.push_back(w[7:0]);
        e.a = AW'(i); e.d = w;
        exp_q.push_back(e);
      end
      exp_err = 1'b0; exp_lat = 2;
`ifdef BOOT_CHECKSUM_EN
      x = 8'h00;
      foreach (stim_q[i]) x = x ^ stim_q[i];
      stim_q.push_back(csum_ok ? x : x ^ 8'($urandom_range(1, 255)));
      exp_err = !csum_ok; exp_lat = 1;
`else
      x = {7'd0, csum_ok};
`endif
    end
    fixed_w.delete();
  endtask

  task automatic send(int max_gap);
    int g;
    foreach (stim_q[i]) begin
      repeat ($urandom_range(0, max_gap)) begin @(negedge clk); rx.rx_valid = 1'b0; end
      @(negedge clk);
      rx.rx_valid = 1'b1;
      rx.rx_data  = stim_q[i];
      g = 0;
      while (rx.rx_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) begin
        total++; bad++;
        $display("FAIL rdy_wait byte=%0d got=stalled want=accepted", i);
        rx.rx_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1 rx.rx_valid = 1'b0;
    end
  endtask

  task automatic wait_term();
    int lat;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      lat = k;
      if (done === 1'b1 || error === 1'b1) break;
    end
    chk("term_lat", 32'(lat), 32'(exp_lat));
    chk("error", 32'(error), 32'(exp_err));
    chk("done", 32'(done), 32'(!exp_err));
    chk("cpu_reset", 32'(cpu_reset), 32'(exp_err));
    chk("busy", 32'(busy), 32'd0);
  endtask

  task automatic restart();
    @(negedge clk);
    boot_start = 1'b1;
    @(posedge clk);
    #1 boot_start = 1'b0;
    @(negedge clk);
    chk("rs_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_error", 32'(error), 32'd0);
    chk("rs_ready", 32'(rx.rx_ready), 32'd1);
  endtask

  task automatic set_tail_outcome();
    exp_err = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    int  k, n;
    reset = 1'b1; boot_start = 1'b0; rx.rx_valid = 1'b0; rx.rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rom_we", 32'(rom_we), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rom_wdata", 32'(rom_wdata), 32'd0);
    chk("rst_ready", 32'(rx.rx_ready), 32'd1);

    // Two-word image, back-to-back then with random valid gaps.
    fixed_w = '{16'h3039, 16'hEC00}; build(2, 1'b1); send(0); wait_term();
    restart();
    fixed_w = '{16'h3039, 16'hEC00}; build(2, 1'b1); send(3); wait_term();
    restart();

    // Zero length.
    build(0, 1'b1); send(0); wait_term();
    restart();

    // Idle after the high byte of word 0: error exactly TO cycles later.
    stim_q = '{8'h00, 8'h02, 8'h30}; send(0);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      k = c;
      if (error === 1'b1) break;
    end
    chk("tmo_cycles", 32'(k), 32'(TO));
    chk("tmo_cpu_reset", 32'(cpu_reset), 32'd1);
    restart();

    // Byte arriving on the expiring cycle wins.
    stim_q = '{8'h00, 8'h02, 8'h30}; send(0);
    e.a = AW'(0); e.d = 16'h3039; exp_q.push_back(e);
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    rx.rx_valid = 1'b1; rx.rx_data = 8'h39;
    @(posedge clk);
    #1 rx.rx_valid = 1'b0;
    chk("tmo_byte_wins", 32'(error), 32'd0);
    e.a = AW'(1); e.d = 16'hEC00; exp_q.push_back(e);
    stim_q = '{8'hEC, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    stim_q.push_back(8'h00 ^ 8'h02 ^ 8'h30 ^ 8'h39 ^ 8'hEC ^ 8'h00);
`endif
    set_tail_outcome();
    send(0); wait_term();
    restart();

    // Reset in the middle of a load, then a clean reload from index 0.
    stim_q = '{8'h00, 8'h03, 8'h11, 8'h22};
    e.a = AW'(0); e.d = 16'h1122; exp_q.push_back(e);
    send(0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_ready", 32'(rx.rx_ready), 32'd1);
    fixed_w = '{16'hABCD}; build(1, 1'b1); send(1); wait_term();
    restart();

    // Boundaries: full image and one past it.
    build(1 << AW, 1'b1); send(1); wait_term();
    restart();
    build((1 << AW) + 1, 1'b1); send(0); wait_term();
    restart();

`ifdef BOOT_CHECKSUM_EN
    fixed_w = '{16'h1234}; build(1, 1'b1); send(0); wait_term();
    restart();
    fixed_w = '{16'h1234}; build(1, 1'b0); send(0); wait_term();
    restart();
`endif

    // Random images, including illegal lengths.
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = (1 << AW) + 1;
        2:       n = 1 << AW;
        3:       n = 16'h0110;
        default: n = $urandom_range(1, 1 << AW);
      endcase
      build(n, $urandom_range(0, 3) != 0);
      send($urandom_range(0, 3));
      wait_term();
      restart();
    end

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
